// File: rtl/mem_lsu.sv
// Load/store unit: sequences data-memory reads/writes for RV32I loads and stores.
// The memory has no byte enables, so SB/SH are done as read-modify-write.
module mem_lsu #(
  parameter int B_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_store,
  input  logic [2:0]         req_funct3,
  input  logic [B_WIDTH-1:0] req_addr,
  input  logic [B_WIDTH-1:0] req_wdata,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [B_WIDTH-1:0] resp_rdata,
  output logic [B_WIDTH-1:0] mem_addr,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [B_WIDTH-1:0] mem_wdata,
  input  logic [B_WIDTH-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // RD1   | first read cycle, memory address presented
  // RD2   | second read cycle, mem_rdata captured at its end
  // WR    | write cycle (SW direct, SB/SH merged word)
  // RESP  | successful completion pulse
  // ERR   | misaligned / illegal access completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_WR, S_RESP, S_ERR
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t             state, state_nxt;
  logic               lat_store;
  logic [2:0]         lat_funct3;
  logic [B_WIDTH-1:0] lat_addr;
  logic [B_WIDTH-1:0] lat_wdata;
  logic [B_WIDTH-1:0] rd_word;
  logic               req_err;
  logic               accept;
  logic [B_WIDTH-1:0] word_idx;
  logic [7:0]         byte_lane;
  logic [15:0]        half_lane;
  logic [B_WIDTH-1:0] load_val;
  logic [B_WIDTH-1:0] merge_word;

  assign accept   = req_valid && (state == S_IDLE);
  assign word_idx = {2'b00, lat_addr[B_WIDTH-1:2]};

  // Error classification is done on the live request so the FSM can branch at acceptance
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = req_addr[0];
      F3_W:    req_err = |req_addr[1:0];
      F3_BU:   req_err = req_store;
      F3_HU:   req_err = req_store | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_store  <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rd_word    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_store  <= req_store;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
      end
      if (state == S_RD2) begin
        rd_word <= mem_rdata;
      end
    end
  end

  always_comb begin
    byte_lane = 8'h00;
    case (lat_addr[1:0])
      2'd0: byte_lane = rd_word[7:0];
      2'd1: byte_lane = rd_word[15:8];
      2'd2: byte_lane = rd_word[23:16];
      2'd3: byte_lane = rd_word[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

    load_val = '0;
    case (lat_funct3)
      F3_B:    load_val = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_val = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_val = rd_word;
      F3_BU:   load_val = {24'h0, byte_lane};
      F3_HU:   load_val = {16'h0, half_lane};
      default: load_val = '0;
    endcase
  end

  // Merged write word: SW ignores rd_word entirely since it never reads
  always_comb begin
    merge_word = rd_word;
    case (lat_funct3)
      F3_B: begin
        case (lat_addr[1:0])
          2'd0: merge_word[7:0]   = lat_wdata[7:0];
          2'd1: merge_word[15:8]  = lat_wdata[7:0];
          2'd2: merge_word[23:16] = lat_wdata[7:0];
          2'd3: merge_word[31:24] = lat_wdata[7:0];
          default: merge_word = rd_word;
        endcase
      end
      F3_H: begin
        if (lat_addr[1]) merge_word[31:16] = lat_wdata[15:0];
        else             merge_word[15:0]  = lat_wdata[15:0];
      end
      default: merge_word = lat_wdata;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                                state_nxt = S_ERR;
          else if (req_store && (req_funct3 == F3_W)) state_nxt = S_WR;
          else                                        state_nxt = S_RD1;
        end
      end
      S_RD1: begin
        mem_read_en = 1'b1;
        mem_addr    = word_idx;
        state_nxt   = S_RD2;
      end
      S_RD2: begin
        mem_read_en = 1'b1;
        mem_addr    = word_idx;
        state_nxt   = lat_store ? S_WR : S_RESP;
      end
      S_WR: begin
        mem_write_en = 1'b1;
        mem_addr     = word_idx;
        mem_wdata    = merge_word;
        state_nxt    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = lat_store ? '0 : load_val;
        state_nxt  = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: transaction-level model of latency, enables and memory
// contents, checked every cycle, plus literal expectations for key results.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_lsu #(.B_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          err;
    int          lat;
    bit          rd;
    int          wrc;
    logic [31:0] rdata;
    logic [31:0] wword;
    logic [31:0] widx;
  } exp_t;

  logic [31:0] tbmem    [0:63];
  logic [31:0] model_mem[0:63];
  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;
  int resp_cnt = 0;
  bit busy = 0;
  int k = 0;
  exp_t cur;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] word);
    exp_t e;
    int sh8, sh16;
    logic [31:0] v, mask;
    sh8  = 8 * int'(a[1:0]);
    sh16 = 16 * int'(a[1]);
    e.err = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && f3 >= 4) ||
            ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 0);
    e.widx = a >> 2;
    e.rdata = 0; e.wword = 0; e.rd = 0; e.wrc = 0; e.lat = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (st) begin
      if (f3 == 2) begin
        e.lat = 2; e.wrc = 1; e.wword = wd;
      end else begin
        e.lat = 4; e.rd = 1; e.wrc = 3;
        mask = (f3 == 0) ? (32'hFF << sh8) : (32'hFFFF << sh16);
        v    = (f3 == 0) ? ((wd & 32'hFF) << sh8) : ((wd & 32'hFFFF) << sh16);
        e.wword = (word & ~mask) | v;
      end
    end else begin
      e.lat = 3; e.rd = 1;
      case (f3)
        3'd0: begin v = (word >> sh8) & 32'hFF;    e.rdata = (v >= 128)   ? (v | 32'hFFFFFF00) : v; end
        3'd4: e.rdata = (word >> sh8) & 32'hFF;
        3'd1: begin v = (word >> sh16) & 32'hFFFF; e.rdata = (v >= 32768) ? (v | 32'hFFFF0000) : v; end
        3'd5: e.rdata = (word >> sh16) & 32'hFFFF;
        default: e.rdata = word;
      endcase
    end
    return e;
  endfunction

  // Memory attached to the DUT: registered read, so data is valid in the second read cycle
  always @(posedge clk) begin
    if (mem_write_en) tbmem[mem_addr[5:0]] <= mem_wdata;
    mem_rdata <= mem_read_en ? tbmem[mem_addr[5:0]] : 32'hBAD0BAD0;
  end

  initial forever begin
    @(posedge clk);
    if (mem_write_en) wr_cnt++;
  end

  // Transaction model: tracks acceptance and the cycle index within the transaction
  initial forever begin
    @(posedge clk);
    if (rst) begin
      busy = 0; k = 0;
    end else if (busy) begin
      if (k == cur.wrc) model_mem[cur.widx[5:0]] = cur.wword;
      k++;
      if (k > cur.lat) begin busy = 0; k = 0; end
    end else if (req_valid) begin
      cur  = predict(req_store, req_funct3, req_addr, req_wdata, model_mem[req_addr[7:2]]);
      busy = 1; k = 1;
      acc_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("rd_wr_exclusive", {31'h0, mem_read_en & mem_write_en}, 32'h0);
    if (rst || !busy) begin
      chk("idle_ready", {31'h0, req_ready}, 32'h1);
      chk("idle_rd_en", {31'h0, mem_read_en}, 32'h0);
      chk("idle_wr_en", {31'h0, mem_write_en}, 32'h0);
      chk("idle_addr", mem_addr, 32'h0);
      chk("idle_wdata", mem_wdata, 32'h0);
      chk("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("idle_resp_err", {31'h0, resp_err}, 32'h0);
      chk("idle_rdata", resp_rdata, 32'h0);
    end else begin
      automatic bit rd_e = cur.rd && (k == 1 || k == 2);
      automatic bit wr_e = (k == cur.wrc);
      automatic bit rv_e = (k == cur.lat);
      chk("busy_ready", {31'h0, req_ready}, 32'h0);
      chk("rd_en", {31'h0, mem_read_en}, {31'h0, rd_e});
      chk("wr_en", {31'h0, mem_write_en}, {31'h0, wr_e});
      chk("mem_addr", mem_addr, (rd_e || wr_e) ? cur.widx : 32'h0);
      chk("mem_wdata", mem_wdata, wr_e ? cur.wword : 32'h0);
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, rv_e});
      chk("resp_err", {31'h0, resp_err}, {31'h0, rv_e && cur.err});
      chk("resp_rdata", resp_rdata, rv_e ? cur.rdata : 32'h0);
    end
    if (resp_valid) begin
      resp_cnt++;
      last_rdata = resp_rdata;
      last_err   = resp_err;
    end
  end

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    int n0, i;
    n0 = acc_cnt;
    @(negedge clk);
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    i = 0;
    while (acc_cnt == n0 && i < 20) begin @(posedge clk); #1; i++; end
    if (acc_cnt == n0) chk("accept_timeout", 32'h0, 32'h1);
    // Request fields change after acceptance; the DUT must use the latched copy
    req_addr = 32'h0000_0020; req_wdata = ~wd; req_funct3 = 3'b010; req_store = ~st;
    if (!hold) req_valid = 1'b0;
    i = 0;
    while (busy && i < 40) begin
      @(negedge clk);
      if (hold && k >= cur.lat) req_valid = 1'b0;
      i++;
    end
    req_valid = 1'b0;
    if (busy) chk("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin tbmem[i] = 32'h0; model_mem[i] = 32'h0; end
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    chk("sw_mem4", tbmem[4], 32'hDEADBEEF);
    chk("sw_err", {31'h0, last_err}, 32'h0);

    issue(1, 3'b010, 32'h10, 32'h8081F2F3, 0);
    issue(0, 3'b000, 32'h12, 32'h0, 0);  chk("lb_0x12", last_rdata, 32'hFFFFFF81);
    issue(0, 3'b100, 32'h12, 32'h0, 0);  chk("lbu_0x12", last_rdata, 32'h00000081);
    issue(0, 3'b101, 32'h10, 32'h0, 0);  chk("lhu_0x10", last_rdata, 32'h0000F2F3);
    issue(0, 3'b001, 32'h12, 32'h0, 0);  chk("lh_0x12", last_rdata, 32'hFFFF8081);
    issue(0, 3'b010, 32'h10, 32'h0, 0);  chk("lw_0x10", last_rdata, 32'h8081F2F3);

    issue(1, 3'b010, 32'h10, 32'h11223344, 0);
    issue(1, 3'b000, 32'h11, 32'h000000AB, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 0);  chk("sb_then_lw", last_rdata, 32'h1122AB44);

    issue(1, 3'b010, 32'h14, 32'hCAFEF00D, 0);
    issue(1, 3'b001, 32'h16, 32'h1234BEEF, 0);
    issue(0, 3'b010, 32'h14, 32'h0, 0);  chk("sh_then_lw", last_rdata, 32'hBEEFF00D);
    issue(0, 3'b000, 32'h17, 32'h0, 0);  chk("lb_0x17", last_rdata, 32'hFFFFFFBE);
    issue(0, 3'b101, 32'h14, 32'h0, 0);  chk("lhu_0x14", last_rdata, 32'h0000F00D);

    issue(0, 3'b010, 32'h12, 32'h0, 0);  chk("err_lw_mis", {31'h0, last_err}, 32'h1);
    issue(1, 3'b001, 32'h11, 32'hFFFF, 0); chk("err_sh_mis", {31'h0, last_err}, 32'h1);
    issue(0, 3'b011, 32'h10, 32'h0, 0);  chk("err_f3_011", {31'h0, last_err}, 32'h1);
    issue(1, 3'b100, 32'h10, 32'h55, 0); chk("err_st_bu", {31'h0, last_err}, 32'h1);
    chk("err_rdata", last_rdata, 32'h0);
    chk("err_mem4_kept", tbmem[4], 32'h1122AB44);

    begin
      automatic int w0 = wr_cnt;
      automatic int a0 = acc_cnt;
      issue(1, 3'b000, 32'h12, 32'h00000055, 1);
      chk("busy_one_write", wr_cnt - w0, 32'd1);
      chk("busy_one_accept", acc_cnt - a0, 32'd1);
      chk("busy_sb_mem4", tbmem[4], 32'h1155AB44);
    end

    begin
      automatic int w0 = wr_cnt;
      automatic int r0 = resp_cnt;
      @(negedge clk);
      req_store = 1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h77; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #2;
      chk("rd2_reached", {31'h0, mem_read_en}, 32'h1);
      rst = 1'b1;
      #1;
      chk("async_rst_rd_en", {31'h0, mem_read_en}, 32'h0);
      chk("async_rst_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_no_write", wr_cnt - w0, 32'd0);
      chk("rst_no_resp", resp_cnt - r0, 32'd0);
      chk("rst_mem4_kept", tbmem[4], 32'h1155AB44);
    end

    issue(0, 3'b010, 32'h10, 32'h0, 0);  chk("post_rst_lw", last_rdata, 32'h1155AB44);
    chk("final_mem4", tbmem[4], model_mem[4]);
    chk("final_mem5", tbmem[5], model_mem[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
